// File: rtl/mmio_stream_port.sv
// Purpose: memory-mapped CPU port bridging STR/LDR to buffered TX/RX byte streams.
// Latency: CPU store visible on tx_valid next cycle; RX byte readable by CPU next cycle; rd is combinational.
// Backpressure: tx_valid/tx_ready and rx_valid/rx_ready handshakes; full TX drops stores (tx_ovf), empty RX loads return 0 (rx_unf).

// Generic circular FIFO with synchronous flush; count is 8 bits, pointers wrap naturally.
module mmio_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [7:0]    count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  // A push into a full FIFO is refused even if a pop frees a slot this cycle;
  // a pop on an empty FIFO is ignored while a simultaneous push still lands.
  assign full    = (count == 8'(DEPTH));
  assign empty   = (count == 8'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is never cleared; only written on an accepted push that is not overridden.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer/count update with reset > flush > push/pop priority.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 8'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 8'd1;
        2'b01:   count <= count - 8'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Top-level peripheral: register decode, sticky error flags, two FIFOs.
module mmio_stream_port #(
  parameter logic [31:0] BASE  = 32'h800,
  parameter int          DEPTH = 4,
  parameter int          DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   a,
  input  logic [31:0]   wd,
  input  logic          we,
  input  logic          re,
  output logic          sel,
  output logic [31:0]   rd,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready
);
  logic [1:0]    off;
  logic [7:0]    tx_count;
  logic [7:0]    rx_count;
  logic [DW-1:0] rx_head;
  logic          tx_full;
  logic          tx_empty;
  logic          rx_full;
  logic          rx_empty;
  logic          tx_ovf;
  logic          rx_unf;
  logic          data_wr;
  logic          data_rd;
  logic          stat_wr;
  logic          ctrl_wr;
  logic          tx_flush;
  logic          rx_flush;
  logic          unused_bits;

  assign sel = (a[31:4] == BASE[31:4]);
  assign off = a[3:2];

  // Byte-lane bits of the address and upper store data have no meaning here.
  assign unused_bits = ^{a[1:0], wd};

  assign data_wr  = sel & we & (off == 2'd0);
  assign data_rd  = sel & re & (off == 2'd0);
  assign stat_wr  = sel & we & (off == 2'd1);
  assign ctrl_wr  = sel & we & (off == 2'd2);
  assign tx_flush = ctrl_wr & wd[0];
  assign rx_flush = ctrl_wr & wd[1];

  assign tx_full  = (tx_count == 8'(DEPTH));
  assign tx_empty = (tx_count == 8'd0);
  assign rx_full  = (rx_count == 8'(DEPTH));
  assign rx_empty = (rx_count == 8'd0);

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  mmio_stream_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (tx_flush),
    .push      (data_wr),
    .push_data (wd[DW-1:0]),
    .pop       (tx_valid & tx_ready),
    .head      (tx_data),
    .count     (tx_count)
  );

  mmio_stream_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (rx_flush),
    .push      (rx_valid & rx_ready),
    .push_data (rx_data),
    .pop       (data_rd),
    .head      (rx_head),
    .count     (rx_count)
  );

  // Sticky error flags: write-1-to-clear, a new event in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (data_wr && tx_full)       tx_ovf <= 1'b1;
      else if (stat_wr && wd[4])    tx_ovf <= 1'b0;
      if (data_rd && rx_empty)      rx_unf <= 1'b1;
      else if (stat_wr && wd[5])    rx_unf <= 1'b0;
    end
  end

  // Combinational read mux; DATA returns the RX head (peek when re is low).
  always_comb begin
    rd = 32'd0;
    if (sel) begin
      case (off)
        2'd0:    rd = {{(32-DW){1'b0}}, (rx_empty ? {DW{1'b0}} : rx_head)};
        2'd1:    rd = {8'h00, rx_count, tx_count, 2'b00, rx_unf, tx_ovf,
                       rx_empty, rx_full, tx_empty, tx_full};
        default: rd = 32'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_stream_port.sv
// Bench for mmio_stream_port: queue scoreboards for TX and RX byte order,
// plus status, flush, address-decode and reset scenarios.
module tb_mmio_stream_port;
  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic        re;
  logic        sel;
  logic [31:0] rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int tests;
  int fails;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  mmio_stream_port #(.BASE(32'h800), .DEPTH(4), .DW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .wd       (wd),
    .we       (we),
    .re       (re),
    .sel      (sel),
    .rd       (rd),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    a  = addr;
    wd = data;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] addr, output logic [31:0] got);
    a  = addr;
    re = 1'b1;
    #1;
    got = rd;
    tick();
    re = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    #1;
    if (rx_ready) rxq.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] got;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cpu_read(32'h804, got);
    tests++;
    if (got !== 32'h0000_000A) begin
      fails++; $display("FAIL reset_status got=%h exp=%h", got, 32'h0000_000A);
    end
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid);
    end
    tests++;
    if (rx_ready !== 1'b1) begin
      fails++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready);
    end
  endtask

  task automatic test_tx_overflow;
    logic [31:0] got;
    logic [7:0]  exp;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (txq.size() < 4) txq.push_back(8'(8'h11 * (i + 1)));
      cpu_write(32'h800, 32'(8'h11 * (i + 1)));
    end
    cpu_read(32'h804, got);
    tests++;
    if (got[15:8] !== 8'd4 || got[0] !== 1'b1 || got[4] !== 1'b1) begin
      fails++; $display("FAIL tx_full_status got=%h exp count=4 full=1 ovf=1", got);
    end
    tx_ready = 1'b1;
    for (int k = 0; k < 10 && txq.size() > 0; k++) begin
      exp = txq.pop_front();
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
        fails++; $display("FAIL tx_drain got=%b/%h exp=1/%h", tx_valid, tx_data, exp);
      end
      tick();
    end
    tests++;
    if (tx_valid !== 1'b0 || txq.size() != 0) begin
      fails++; $display("FAIL tx_drained got=%b exp=0 left=%0d", tx_valid, txq.size());
    end
    tx_ready = 1'b0;
    cpu_write(32'h804, 32'h10);
    cpu_read(32'h804, got);
    tests++;
    if (got[4] !== 1'b0) begin
      fails++; $display("FAIL tx_ovf_clear got=%h exp bit4=0", got);
    end
  endtask

  task automatic test_rx_underflow;
    logic [31:0] got;
    logic [7:0]  b;
    logic [7:0]  exp;
    for (int i = 0; i < 7; i++) begin
      b = (i == 0) ? 8'hA5 : (i == 1) ? 8'h5A : 8'hC3;
      rx_data  = b;
      rx_valid = 1'b1;
      #1;
      tests++;
      if (rx_ready !== (rxq.size() != 4)) begin
        fails++; $display("FAIL rx_ready_%0d got=%b exp=%b", i, rx_ready, rxq.size() != 4);
      end
      if (rxq.size() < 4) rxq.push_back(b);
      tick();
    end
    rx_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cpu_read(32'h800, got);
      exp = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
      tests++;
      if (got !== {24'h0, exp}) begin
        fails++; $display("FAIL rx_load_%0d got=%h exp=%h", k, got, exp);
      end
    end
    cpu_read(32'h800, got);
    tests++;
    if (got !== 32'h0) begin
      fails++; $display("FAIL rx_empty_load got=%h exp=0", got);
    end
    cpu_read(32'h804, got);
    tests++;
    if (got[5] !== 1'b1 || got[3] !== 1'b1) begin
      fails++; $display("FAIL rx_unf_status got=%h exp bit5=1 bit3=1", got);
    end
    cpu_write(32'h804, 32'h20);
    cpu_read(32'h804, got);
    tests++;
    if (got !== 32'h0000_000A) begin
      fails++; $display("FAIL rx_unf_clear got=%h exp=%h", got, 32'h0000_000A);
    end
  endtask

  task automatic test_rx_simultaneous;
    logic [31:0] got;
    logic [7:0]  exp;
    rx_send(8'h77);
    a        = 32'h800;
    re       = 1'b1;
    rx_data  = 8'h88;
    rx_valid = 1'b1;
    #1;
    got = rd;
    exp = rxq.pop_front();
    rxq.push_back(8'h88);
    tick();
    re       = 1'b0;
    rx_valid = 1'b0;
    tests++;
    if (got !== {24'h0, exp}) begin
      fails++; $display("FAIL rx_simul_head got=%h exp=%h", got, exp);
    end
    cpu_read(32'h804, got);
    tests++;
    if (got[23:16] !== 8'(rxq.size())) begin
      fails++; $display("FAIL rx_simul_count got=%0d exp=%0d", got[23:16], rxq.size());
    end
    cpu_read(32'h800, got);
    exp = rxq.pop_front();
    tests++;
    if (got !== {24'h0, exp}) begin
      fails++; $display("FAIL rx_simul_next got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_flush;
    logic [31:0] got;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      txq.push_back(8'(8'hA1 + i));
      cpu_write(32'h800, 32'(8'hA1 + i));
    end
    rx_send(8'hB1);
    rx_send(8'hB2);
    cpu_read(32'h804, got);
    tests++;
    if (got[15:8] !== 8'(txq.size()) || got[23:16] !== 8'(rxq.size())) begin
      fails++; $display("FAIL pre_flush_counts got=%h exp tx=%0d rx=%0d", got, txq.size(), rxq.size());
    end
    cpu_write(32'h808, 32'h3);
    txq.delete();
    rxq.delete();
    cpu_read(32'h804, got);
    tests++;
    if (got !== 32'h0000_000A || tx_valid !== 1'b0) begin
      fails++; $display("FAIL flush got=%h/%b exp=%h/0", got, tx_valid, 32'h0000_000A);
    end
    a  = 32'h810;
    wd = 32'h55;
    we = 1'b1;
    #1;
    tests++;
    if (sel !== 1'b0 || rd !== 32'h0) begin
      fails++; $display("FAIL out_of_window got sel=%b rd=%h exp 0/0", sel, rd);
    end
    tick();
    we = 1'b0;
    cpu_read(32'h804, got);
    tests++;
    if (got !== 32'h0000_000A || tx_valid !== 1'b0) begin
      fails++; $display("FAIL out_of_window_state got=%h exp=%h", got, 32'h0000_000A);
    end
  endtask

  task automatic test_wrap_reset;
    logic [7:0] exp;
    logic       accept;
    for (int i = 0; i < 10; i++) begin
      a        = 32'h800;
      wd       = 32'(i);
      we       = 1'b1;
      tx_ready = (i >= 2);
      #1;
      accept = (txq.size() < 4);
      tests++;
      if (tx_valid !== (txq.size() != 0)) begin
        fails++; $display("FAIL wrap_valid_%0d got=%b exp=%b", i, tx_valid, txq.size() != 0);
      end
      if (tx_valid && tx_ready) begin
        exp = txq.pop_front();
        tests++;
        if (tx_data !== exp) begin
          fails++; $display("FAIL wrap_data_%0d got=%h exp=%h", i, tx_data, exp);
        end
      end
      if (accept) txq.push_back(8'(i));
      tick();
    end
    we       = 1'b0;
    tx_ready = 1'b1;
    for (int k = 0; k < 20 && txq.size() > 0; k++) begin
      exp = txq.pop_front();
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
        fails++; $display("FAIL wrap_drain got=%b/%h exp=1/%h", tx_valid, tx_data, exp);
      end
      tick();
    end
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL wrap_empty got=%b exp=0", tx_valid);
    end
    tx_ready = 1'b0;
    cpu_write(32'h800, 32'hE1);
    cpu_write(32'h800, 32'hE2);
    tests++;
    if (tx_valid !== 1'b1) begin
      fails++; $display("FAIL pre_reset_valid got=%b exp=1", tx_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    txq.delete();
    tests++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset got tx_valid=%b rx_ready=%b exp 0/1", tx_valid, rx_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    a        = 32'h0;
    wd       = 32'h0;
    we       = 1'b0;
    re       = 1'b0;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tests    = 0;
    fails    = 0;
    test_reset();
    test_tx_overflow();
    test_rx_underflow();
    test_rx_simultaneous();
    test_flush();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmio_stream_port.md
Name: mmio_stream_port

Overview:
- Memory-mapped responder peripheral on the single-cycle ARM core's data bus (DataAdr/WriteData/MemWrite/load strobe).
- Converts processor STR/LDR accesses into buffered 8-bit valid/ready streams:
  - a TX FIFO from CPU to external device;
  - an RX FIFO from external device to CPU.
- Replaces the unbuffered IN/OUT port pair so that software can poll status instead of losing bytes.
- Sits beside dmem; the top level muxes rd into ReadData when sel is high.

Parameters:
- BASE, 32'h800: word-aligned base address; window is BASE..BASE+0xC.
- DEPTH, 4: entries per FIFO. Must be a power of two, 2..128.
- DW, 8: stream data width, 1..8.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- a  in  32  CPU data address (ALUResult)
- wd  in  32  CPU store data
- we  in  1  qualified store strobe (MemWrite, already condition-gated)
- re  in  1  qualified load strobe (load and CondEx)
- sel  out  1  address hit: a[31:4] == BASE[31:4]
- rd  out  32  combinational read data, valid the same cycle as a
- tx_data  out  DW  head of TX FIFO
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  external sink accepts tx_data
- rx_data  in  DW  external source data
- rx_valid  in  1  external source has data
- rx_ready  out  1  RX FIFO not full

Behaviour:
- Register map (offset = a[3:2]):
  - 0 DATA
  - 1 STATUS
  - 2 CTRL
  - 3 reserved: reads 0, writes ignored.
- Accesses act only when sel is high; a[1:0] is ignored.
- rd is 0 when sel is low.
- DATA write (we): pushes wd[DW-1:0] into TX at the clock edge if tx_count < DEPTH.
  - If full, the byte is dropped and sticky tx_ovf is set.
  - A push into a full FIFO is dropped even if tx pops that same cycle.
- DATA read (re): rd = zero-extended RX head, combinational.
  - Pops RX at the edge if non-empty.
  - If empty: rd = 0, no pop, sticky rx_unf is set.
- A DATA read with re low returns the head without popping (peek).
- STATUS read: rd fields are:
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty
  - [4] tx_ovf, [5] rx_unf
  - [15:8] tx_count, [23:16] rx_count
  - all other bits 0.
- STATUS write: write-1-to-clear. wd[4] clears tx_ovf; wd[5] clears rx_unf; other bits are ignored.
  - If a clear and a new set of the same flag occur in one cycle, set wins.
- CTRL write: wd[0] flushes TX; wd[1] flushes RX. Flush empties the FIFO (pointers and count go to 0) at that edge and is self-clearing.
- CTRL reads 0.
- TX stream side:
  - tx_valid = (tx_count != 0); tx_data = TX head.
  - Pop at the edge when tx_valid & tx_ready.
  - Data must be held stable while tx_valid is high and tx_ready is low.
- RX stream side:
  - rx_ready = (rx_count != DEPTH), derived from registered count.
  - Push at the edge when rx_valid & rx_ready.
- Counters and pointers:
  - Counts are 8 bits wide.
  - Pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged and advances both pointers.
  - Simultaneous push and pop on an empty FIFO: the pop is invalid and the push proceeds (count becomes 1).
- Priority: reset > flush > push/pop.
  - Flush in the same cycle as a push discards the pushed byte.
  - Flush in the same cycle as a stream handshake discards it. For TX, tx_ready&tx_valid that cycle is still treated as consumed by the sink; the sink must tolerate this.
- Reset (synchronous, the edge with reset high):
  - Counts, pointers, tx_ovf and rx_unf go to 0.
  - Stream inputs and CPU strobes are ignored that cycle.
  - After reset: tx_valid = 0, rx_ready = 1, tx_data undefined (not checked).
  - FIFO storage is not cleared.
  - Reset mid-transfer abandons all queued data.
- Latency:
  - A byte stored by CPU is visible on tx_valid the next cycle.
  - A byte accepted on RX is readable by CPU the next cycle.
  - STATUS reflects state after the last edge.

Test Plan:
- Reset, then read STATUS at 0x804 -> rd = 32'h0000_000A (tx_empty, rx_empty). tx_valid = 0; rx_ready = 1.
- With tx_ready = 0, store 0x11,0x22,0x33,0x44,0x55 to 0x800 -> STATUS [15:8] = 4, bit0 = 1, bit4 = 1. Then raise tx_ready -> tx_data sequence 11,22,33,44 on consecutive cycles, then tx_valid = 0. Write 0x10 to 0x804 -> bit4 clears.
- Drive rx bytes A5, 5A, with rx_valid held for 5 cycles of value C3 and DEPTH = 4 -> rx_ready low after 4 accepted. Loads from 0x800 return A5, 5A, C3, C3, then 0 with STATUS bit5 = 1.
- Load from 0x800 with rx_count = 1 while rx_valid pushes the same cycle -> rd = old head, rx_count remains 1, next load returns the new byte.
- Store 0x3 to 0x808 while tx_count = 3, rx_count = 2, and a CPU store to DATA is not issued the same cycle -> both counts 0, tx_valid = 0. Also: address 0x810 store -> sel = 0, no state change.
- Pointer wrap: push/pop 10 bytes (0x00..0x09) interleaved through TX -> output order preserved across two wrap-arounds. Assert reset mid-stream -> tx_valid = 0 next cycle.
